// File: rtl/minimips_pkg.sv
// Shared definitions for the MiniMIPS instruction-side blocks: instruction
// word width, the filler word served on invalid fetches, and the loader states.
package minimips_pkg;

    localparam int IWIDTH = 16;

    localparam logic [IWIDTH-1:0] NOP_WORD = 16'h0000;

    // LOAD: accepting the program stream. RUN: serving fetches to the core.
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } loader_state_t;

endpackage

// File: rtl/imem_array.sv
// Program store: DEPTH x IWIDTH register array with one synchronous write
// port and one asynchronous read port. Deliberately has no reset; the loader
// bounds every read with its word count, so stale contents are never served.
module imem_array #(
    parameter int IWIDTH = 16,
    parameter int DEPTH  = 30,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [IWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [IWIDTH-1:0] rdata
);

    logic [IWIDTH-1:0] mem [DEPTH];

    // Write port: store one program word on the accepting edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: zero-latency lookup; address codes past the last row read as zero.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_loader_memory.sv
// Instruction-side responder for MiniMIPS: takes a program as a stream of
// instruction words, then serves instruction = mem[PCounter] while running.
// Fetches at or beyond the loaded word count return NOP_WORD and set a
// sticky fault flag that only reset or reload clears.
module instruction_loader_memory #(
    parameter int                IWIDTH   = minimips_pkg::IWIDTH,
    parameter int                DEPTH    = 30,
    parameter int                PCW      = 32,
    parameter logic [IWIDTH-1:0] NOP_WORD = minimips_pkg::NOP_WORD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    input  logic [IWIDTH-1:0]            load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    input  logic                         reload,
    input  logic [PCW-1:0]               PCounter,
    output logic [IWIDTH-1:0]            instruction,
    output logic                         run,
    output logic [$clog2(DEPTH+1)-1:0]   loaded_count,
    output logic                         fetch_fault
);

    import minimips_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    loader_state_t state;
    loader_state_t next_state;

    logic              accept;
    logic              final_word;
    logic              in_range;
    logic [IWIDTH-1:0] rdata;

    // A word is taken only in LOAD; a simultaneous reload drops it.
    assign accept     = (state == LOAD) && load_valid && !reload;
    // Index DEPTH-1 fills the array, so it ends the load even without load_last.
    assign final_word = load_last || (loaded_count == CW'(DEPTH - 1));
    // Compare across the full PC width so large PCs never alias onto stored words.
    assign in_range   = (PCounter < PCW'(loaded_count));

    imem_array #(
        .IWIDTH (IWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_imem_array (
        .clk   (clk),
        .we    (accept),
        .waddr (loaded_count[AW-1:0]),
        .wdata (load_data),
        .raddr (PCounter[AW-1:0]),
        .rdata (rdata)
    );

    // State register: reset always returns to LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next state: reload wins over everything; the final accepted word enters RUN.
    always_comb begin
        next_state = state;
        if (reload) begin
            next_state = LOAD;
        end else if (accept && final_word) begin
            next_state = RUN;
        end
    end

    // Handshake outputs decoded purely from the state register.
    always_comb begin
        load_ready = 1'b0;
        run        = 1'b0;
        case (state)
            LOAD:    load_ready = 1'b1;
            RUN:     run        = 1'b1;
            default: begin
                load_ready = 1'b0;
                run        = 1'b0;
            end
        endcase
    end

    // Word counter: doubles as the write index and the upper bound for fetches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded_count <= '0;
        end else if (reload) begin
            loaded_count <= '0;
        end else if (accept) begin
            loaded_count <= loaded_count + CW'(1);
        end
    end

    // Sticky fault: any out-of-range fetch sampled while running latches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_fault <= 1'b0;
        end else if (reload) begin
            fetch_fault <= 1'b0;
        end else if ((state == RUN) && !in_range) begin
            fetch_fault <= 1'b1;
        end
    end

    // Fetch path: stored word only when running and inside the program, else NOP.
    always_comb begin
        instruction = NOP_WORD;
        if ((state == RUN) && in_range) begin
            instruction = rdata;
        end
    end

endmodule

// File: tb/tb_instruction_loader_memory.sv
// Directed bench for instruction_loader_memory: loads programs through the
// stream interface and checks handshake, counter, fetch path and fault flag
// against hand-computed values.
module tb_instruction_loader_memory;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        reload;
    logic [31:0] PCounter;
    logic [15:0] instruction;
    logic        run;
    logic [4:0]  loaded_count;
    logic        fetch_fault;

    int compareCount;
    int mismatchCount;

    instruction_loader_memory dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .reload       (reload),
        .PCounter     (PCounter),
        .instruction  (instruction),
        .run          (run),
        .loaded_count (loaded_count),
        .fetch_fault  (fetch_fault)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stream/reload inputs from the falling edge, then release them
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic l, input logic r);
        @(negedge clk);
        load_valid = v;
        load_data  = d;
        load_last  = l;
        reload     = r;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        reload     = 1'b0;
        #1;
    endtask

    // Present a PC and check the combinational fetch result
    task automatic checkFetch(input string tag, input logic [31:0] pc, input logic [15:0] expected);
        PCounter = pc;
        #1;
        checkOutput(tag, {16'h0, instruction}, {16'h0, expected});
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_last  = 1'b0;
        reload     = 1'b0;
        PCounter   = 32'h0;

        // Reset values
        #3;
        checkOutput("rst_ready", {31'h0, load_ready},   32'h1);
        checkOutput("rst_run",   {31'h0, run},          32'h0);
        checkOutput("rst_count", {27'h0, loaded_count}, 32'h0);
        checkOutput("rst_fault", {31'h0, fetch_fault},  32'h0);
        checkOutput("rst_instr", {16'h0, instruction},  32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Three-word program with load_last on the third word
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
        checkOutput("p3_count2", {27'h0, loaded_count}, 32'd2);
        checkOutput("p3_run_lo", {31'h0, run},          32'h0);
        checkOutput("p3_load_instr", {16'h0, instruction}, 32'h0);
        applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0);
        checkOutput("p3_count3", {27'h0, loaded_count}, 32'd3);
        checkOutput("p3_run",    {31'h0, run},          32'h1);
        checkOutput("p3_ready",  {31'h0, load_ready},   32'h0);
        checkFetch("p3_fetch0", 32'd0, 16'h1111);
        checkFetch("p3_fetch1", 32'd1, 16'h2222);
        checkFetch("p3_fetch2", 32'd2, 16'h3333);
        idleCycle();
        checkOutput("p3_nofault", {31'h0, fetch_fault}, 32'h0);

        // load_valid ignored while running
        applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0);
        checkOutput("run_ignore_count", {27'h0, loaded_count}, 32'd3);

        // Out-of-range fetches: NOP, then sticky fault
        checkFetch("oor_fetch3", 32'd3, 16'h0000);
        checkOutput("oor_fault_before_edge", {31'h0, fetch_fault}, 32'h0);
        idleCycle();
        checkOutput("oor_fault_set", {31'h0, fetch_fault}, 32'h1);
        PCounter = 32'd0;
        idleCycle();
        checkOutput("oor_fault_sticky", {31'h0, fetch_fault}, 32'h1);
        checkFetch("oor_big_pc",   32'h8000_0001, 16'h0000);
        checkFetch("oor_alias_pc", 32'h0000_0020, 16'h0000);

        // reload together with load_last: reload wins, word dropped, fault cleared
        applyStimulus(1'b1, 16'hAAAA, 1'b1, 1'b1);
        checkOutput("rl_run",   {31'h0, run},          32'h0);
        checkOutput("rl_ready", {31'h0, load_ready},   32'h1);
        checkOutput("rl_count", {27'h0, loaded_count}, 32'h0);
        checkOutput("rl_fault", {31'h0, fetch_fault},  32'h0);

        // Gapped stream: only valid cycles write, order preserved
        PCounter = 32'd0;
        applyStimulus(1'b1, 16'h0101, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hDEAD, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0202, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hBEEF, 1'b1, 1'b0);
        checkOutput("gap_count2", {27'h0, loaded_count}, 32'd2);
        checkOutput("gap_still_load", {31'h0, run}, 32'h0);
        applyStimulus(1'b1, 16'h0303, 1'b1, 1'b0);
        checkOutput("gap_count3", {27'h0, loaded_count}, 32'd3);
        checkFetch("gap_fetch0", 32'd0, 16'h0101);
        checkFetch("gap_fetch1", 32'd1, 16'h0202);
        checkFetch("gap_fetch2", 32'd2, 16'h0303);

        // Full 30-word program without load_last
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        PCounter = 32'd0;
        for (int i = 0; i < 29; i++) begin
            applyStimulus(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
        end
        checkOutput("full_count29", {27'h0, loaded_count}, 32'd29);
        checkOutput("full_run_lo",  {31'h0, run},          32'h0);
        applyStimulus(1'b1, 16'h501D, 1'b0, 1'b0);
        checkOutput("full_count30", {27'h0, loaded_count}, 32'd30);
        checkOutput("full_run",     {31'h0, run},          32'h1);
        applyStimulus(1'b1, 16'h9999, 1'b0, 1'b0);
        checkOutput("full_no_overflow", {27'h0, loaded_count}, 32'd30);
        checkFetch("full_fetch0",  32'd0,  16'h5000);
        checkFetch("full_fetch15", 32'd15, 16'h500F);
        checkFetch("full_fetch29", 32'd29, 16'h501D);
        idleCycle();
        checkOutput("full_fault_clear", {31'h0, fetch_fault}, 32'h0);
        checkFetch("full_fetch30", 32'd30, 16'h0000);
        idleCycle();
        checkOutput("full_fault_set", {31'h0, fetch_fault}, 32'h1);

        // Asynchronous reset in the middle of a load
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        PCounter = 32'd0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
        end
        checkOutput("mid_count5", {27'h0, loaded_count}, 32'd5);
        reset = 1'b1;
        #1;
        checkOutput("async_count", {27'h0, loaded_count}, 32'h0);
        checkOutput("async_ready", {31'h0, load_ready},   32'h1);
        checkOutput("async_run",   {31'h0, run},          32'h0);
        checkOutput("async_instr", {16'h0, instruction},  32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 16'hB001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hB002, 1'b1, 1'b0);
        checkOutput("new_count", {27'h0, loaded_count}, 32'd2);
        checkOutput("new_run",   {31'h0, run},          32'h1);
        checkFetch("new_fetch0", 32'd0, 16'hB001);
        checkFetch("new_fetch1", 32'd1, 16'hB002);
        checkFetch("new_fetch2", 32'd2, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/instruction_loader_memory.md
# instruction_loader_memory

Instruction-side responder for the MiniMIPS core: accepts a program as a stream of 16-bit instruction words, stores it, then serves `instruction` for the word index presented on `PCounter`. It replaces the bench-level instruction array so the core can run from a synthesizable program store. It also gates execution through `run` and flags fetches beyond the loaded program.

## Interface
Parameters:
- `IWIDTH`, 16, instruction word width
- `DEPTH`, 30, number of instruction words stored
- `PCW`, 32, width of `PCounter`
- `NOP_WORD`, 16'h0000, word returned for any fetch that is not valid

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `load_valid`  in  1  a program word is present on `load_data`
- `load_data`  in  IWIDTH  program word
- `load_last`  in  1  qualifies the final word of the program
- `load_ready`  out  1  the block accepts a word this cycle
- `reload`  in  1  one-cycle request to discard the program and reload
- `PCounter`  in  PCW  word index fetched by the core
- `instruction`  out  IWIDTH  fetched word
- `run`  out  1  program is loaded and the core may execute
- `loaded_count`  out  $clog2(DEPTH+1)  number of words stored
- `fetch_fault`  out  1  sticky flag: out-of-range fetch while running

## Operation
- Two-state FSM with states LOAD and RUN. Reset enters LOAD.
- LOAD:
  - `load_ready`=1.
  - On `load_valid && load_ready`, write `load_data` to `mem[loaded_count]` and increment `loaded_count`.
  - Go to RUN when the accepted word carries `load_last`, or when it is word index DEPTH-1. The array is full at that point, so overflow cannot occur.
- RUN:
  - `load_ready`=0. `load_valid` is ignored.
  - `run`=1.
  - `instruction` = `mem[PCounter]` when `PCounter < loaded_count`. Otherwise it is `NOP_WORD`. All PCW bits are compared, so large PC values never alias onto valid words.
- `fetch_fault`:
  - Set on a clock edge in RUN when `PCounter >= loaded_count`.
  - Remains set until `reset` or `reload`.
- `reload`, in any state:
  - Go to LOAD, zero `loaded_count`, clear `fetch_fault`.
  - A word presented in the same cycle is not accepted.
  - In LOAD, `reload` restarts the load at index 0.
- In LOAD, `instruction` = `NOP_WORD` and `run`=0.
- Memory contents are not cleared by `reset`. Unwritten entries are unreachable because of the `loaded_count` bound.

## Timing
- Reset values:
  - state=LOAD, `load_ready`=1
  - `run`=0
  - `loaded_count`=0
  - `fetch_fault`=0
  - `instruction`=`NOP_WORD`
- `load_ready` and `run` are decoded directly from the state register, with no combinational path from inputs.
- A word is written on the edge where valid and ready are both high. `loaded_count` shows the new value in the following cycle.
- The last-word edge moves the state to RUN. `run`=1 and `load_ready`=0 from the next cycle.
- The read path is combinational, with zero-cycle latency from `PCounter` to `instruction`. This matches the core's single-cycle fetch.
- `fetch_fault` asserts one cycle after the offending `PCounter` is sampled.
- `reload` and `load_last` on the same edge: `reload` wins. The word is dropped and the state is LOAD.
- `reset` asserted mid-load forces LOAD with count 0 asynchronously. Partial programs are discarded.

## Structure
- Shared package `minimips_pkg`:
  - `IWIDTH`
  - `NOP_WORD`
  - the two-value state enumeration
- Sub-module `imem_array`:
  - DEPTH×IWIDTH register array
  - one synchronous write port
  - one asynchronous read port
  - no reset
- The FSM, counter, and range check live in the top module.

## Test plan
- Load 3 words 16'h1111, 16'h2222, 16'h3333 (last on the third) → `loaded_count`=3, `run`=1 the cycle after. `PCounter`=0/1/2 returns those words. `fetch_fault`=0.
- Load 30 words without `load_last` → RUN after the 30th. A 31st `load_valid` is not accepted and `loaded_count` stays 30.
- In RUN with 3 words loaded, `PCounter`=3 → `instruction`=16'h0000, and `fetch_fault`=1 next cycle and stays set. `PCounter`=32'h8000_0001 also gives NOP.
- Toggle `load_valid` with gaps → only valid cycles write, and the order is preserved at indices 0..n-1.
- Assert `reload` and `load_last` on the same cycle, with `fetch_fault` set → next cycle state=LOAD, count=0, fault=0. The word is not stored.
- Assert `reset` asynchronously mid-load (count=5, between edges) → outputs reach reset values immediately. A reload of 2 words serves the new words.
